// File: rtl/mdu_multicycle.sv
`default_nettype none
//==============================================================================
// Module      : mdu_multicycle
// Description : Multi-cycle multiply/divide unit with HI/LO registers,
//               start/busy handshake and a remaining-cycles count.
//               Optional MADD/MADDU/MSUB/MSUBU enabled by macro MDU_MACC_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module mdu_multicycle #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic             rd_hi,
   output logic [WIDTH-1:0] rdata,
   output logic             busy,
   output logic [CNT_W-1:0] remain,
   output logic             accept,
   output logic             illegal
);

   localparam logic [3:0] c_OP_NOP   = 4'd0;
   localparam logic [3:0] c_OP_MULT  = 4'd1;
   localparam logic [3:0] c_OP_MULTU = 4'd2;
   localparam logic [3:0] c_OP_DIV   = 4'd3;
   localparam logic [3:0] c_OP_DIVU  = 4'd4;
   localparam logic [3:0] c_OP_MTHI  = 4'd5;
   localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MDU_MACC_EN
   localparam logic [3:0] c_OP_MADD  = 4'd7;
   localparam logic [3:0] c_OP_MADDU = 4'd8;
   localparam logic [3:0] c_OP_MSUB  = 4'd9;
   localparam logic [3:0] c_OP_MSUBU = 4'd10;
   localparam logic [3:0] c_OP_LAST  = c_OP_MSUBU;
`else
   localparam logic [3:0] c_OP_LAST  = c_OP_MTLO;
`endif

   localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] c_DIV_CNT = CNT_W'(DIV_CYCLES);

   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_pend;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_accept;
   logic               r_illegal;

   logic               w_legal;
   logic               w_take;
   logic               w_bad;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic               w_sa;
   logic               w_sb;
   logic [WIDTH-1:0]   w_amag;
   logic [WIDTH-1:0]   w_bmag;
   logic [WIDTH-1:0]   w_qmag;
   logic [WIDTH-1:0]   w_rmag;
   logic [2*WIDTH-1:0] w_div_res;
`ifdef MDU_MACC_EN
   logic [2*WIDTH-1:0] w_acc;
`endif

   assign busy    = (r_cnt != '0);
   assign remain  = r_cnt;
   assign accept  = r_accept;
   assign illegal = r_illegal;
   assign rdata   = rd_hi ? r_hi : r_lo;

   assign w_legal = (op <= c_OP_LAST);
   assign w_take  = start && !busy && w_legal;
   assign w_bad   = start && !busy && !w_legal;

   // Low 2W bits of the sign-extended product equal the two's-complement product
   assign w_prod_s = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
   assign w_prod_u = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};

   // Signed divide on magnitudes; most-negative / -1 naturally wraps to itself
   assign w_sa   = (op == c_OP_DIV) && d1[WIDTH-1];
   assign w_sb   = (op == c_OP_DIV) && d2[WIDTH-1];
   assign w_amag = w_sa ? (~d1 + 1'b1) : d1;
   assign w_bmag = w_sb ? (~d2 + 1'b1) : d2;
   assign w_qmag = (w_bmag == '0) ? '0 : (w_amag / w_bmag);
   assign w_rmag = (w_bmag == '0) ? '0 : (w_amag % w_bmag);

   always_comb begin
      w_div_res = '0;
      if (d2 == '0) begin
         w_div_res = {d1, {WIDTH{1'b1}}};
      end else begin
         w_div_res[WIDTH-1:0]       = (w_sa ^ w_sb) ? (~w_qmag + 1'b1) : w_qmag;
         w_div_res[2*WIDTH-1:WIDTH] = w_sa ? (~w_rmag + 1'b1) : w_rmag;
      end
   end

`ifdef MDU_MACC_EN
   assign w_acc = {r_hi, r_lo};
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend    <= '0;
         r_cnt     <= '0;
         r_accept  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_accept  <= w_take;
         r_illegal <= w_bad;
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               {r_hi, r_lo} <= r_pend;
            end
         end else if (w_take) begin
            case (op)
               c_OP_NOP: ;
               c_OP_MULT: begin
                  r_pend <= w_prod_s;
                  r_cnt  <= c_MUL_CNT;
               end
               c_OP_MULTU: begin
                  r_pend <= w_prod_u;
                  r_cnt  <= c_MUL_CNT;
               end
               c_OP_DIV, c_OP_DIVU: begin
                  r_pend <= w_div_res;
                  r_cnt  <= c_DIV_CNT;
               end
               c_OP_MTHI: r_hi <= d1;
               c_OP_MTLO: r_lo <= d1;
`ifdef MDU_MACC_EN
               c_OP_MADD: begin
                  r_pend <= w_acc + w_prod_s;
                  r_cnt  <= c_MUL_CNT;
               end
               c_OP_MADDU: begin
                  r_pend <= w_acc + w_prod_u;
                  r_cnt  <= c_MUL_CNT;
               end
               c_OP_MSUB: begin
                  r_pend <= w_acc - w_prod_s;
                  r_cnt  <= c_MUL_CNT;
               end
               c_OP_MSUBU: begin
                  r_pend <= w_acc - w_prod_u;
                  r_cnt  <= c_MUL_CNT;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_multicycle.sv
`default_nettype none
//==============================================================================
// Module      : tb_mdu_multicycle
// Description : Self-checking bench for mdu_multicycle (vector table plus
//               hand-written latency, busy, reset and accumulate sequences).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mdu_multicycle;
   localparam int WIDTH      = 32;
   localparam int MUL_CYCLES = 5;
   localparam int DIV_CYCLES = 10;
   localparam int CNT_W      = 5;

   logic             clk   = 1'b0;
   logic             rst   = 1'b0;
   logic             start = 1'b0;
   logic [3:0]       op    = 4'd0;
   logic [WIDTH-1:0] d1    = '0;
   logic [WIDTH-1:0] d2    = '0;
   logic             rd_hi = 1'b0;
   logic [WIDTH-1:0] rdata;
   logic             busy;
   logic [CNT_W-1:0] remain;
   logic             accept;
   logic             illegal;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;

   mdu_multicycle #(
      .WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .d1(d1), .d2(d2),
      .rd_hi(rd_hi), .rdata(rdata), .busy(busy), .remain(remain),
      .accept(accept), .illegal(illegal)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic read_hilo(output logic [63:0] v);
      rd_hi = 1'b1; #1; v[63:32] = rdata;
      rd_hi = 1'b0; #1; v[31:0]  = rdata;
   endtask

   task automatic pop_check(input string name);
      logic [63:0] v;
      logic [63:0] e;
      read_hilo(v);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty, got %h", name, v);
      end else begin
         e = exp_q.pop_front();
         chk({name, " hilo"}, v, e);
      end
   endtask

   task automatic wait_idle(input string name, output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) chk({name, " timeout busy"}, 64'(busy), 64'd0);
   endtask

   task automatic issue(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] e, input int lat);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; d1 = a; d2 = b;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0; d1 = $urandom; d2 = $urandom;
      chk({name, " accept"}, 64'(accept), 64'd1);
      wait_idle(name, n);
      chk({name, " latency"}, 64'(n), 64'(lat));
      pop_check(name);
   endtask

   task automatic move(input string name, input logic [3:0] o, input logic [31:0] a,
                       input logic [63:0] e);
      logic [63:0] v;
      @(negedge clk);
      start = 1'b1; op = o; d1 = a; d2 = '0;
      @(negedge clk);
      start = 1'b0;
      chk({name, " accept"}, 64'(accept), 64'd1);
      chk({name, " busy"}, 64'(busy), 64'd0);
      read_hilo(v);
      chk({name, " hilo"}, v, e);
   endtask

   initial begin
      logic [63:0] v;
      int n;

      vecs[0] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MUL_CYCLES};
      vecs[1] = '{4'd1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, MUL_CYCLES};
      vecs[2] = '{4'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_80000001, MUL_CYCLES};
      vecs[3] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, DIV_CYCLES};
      vecs[4] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, DIV_CYCLES};
      vecs[5] = '{4'd4, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, DIV_CYCLES};
      vecs[6] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DIV_CYCLES};
      vecs[7] = '{4'd4, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, DIV_CYCLES};
      vecs[8] = '{4'd3, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, DIV_CYCLES};

      // Reset defaults
      repeat (2) @(negedge clk);
      read_hilo(v);
      chk("reset hilo", v, 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset remain", 64'(remain), 64'd0);
      chk("reset accept", 64'(accept), 64'd0);
      chk("reset illegal", 64'(illegal), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // MULT latency and remain countdown
      @(negedge clk);
      start = 1'b1; op = 4'd1; d1 = 32'hFFFFFFFE; d2 = 32'd3;
      exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < MUL_CYCLES; i++) begin
         chk($sformatf("mult remain %0d", i), 64'(remain), 64'(MUL_CYCLES - i));
         chk($sformatf("mult busy %0d", i), 64'(busy), 64'd1);
         if (i == MUL_CYCLES - 1) begin
            read_hilo(v);
            chk("mult precommit hilo", v, 64'd0);
         end
         @(negedge clk);
      end
      chk("mult busy end", 64'(busy), 64'd0);
      chk("mult remain end", 64'(remain), 64'd0);
      pop_check("mult");

      for (int i = 0; i < 9; i++)
         issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Start while busy is ignored
      @(negedge clk);
      start = 1'b1; op = 4'd2; d1 = 32'd6; d2 = 32'd7;
      exp_q.push_back(64'd42);
      @(negedge clk);
      op = 4'd4; d1 = 32'd100; d2 = 32'd9;
      chk("busyrej first accept", 64'(accept), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("busyrej no accept %0d", i), 64'(accept), 64'd0);
      end
      start = 1'b0;
      wait_idle("busyrej", n);
      pop_check("busyrej");
      issue("divu reissue", 4'd4, 32'd100, 32'd9, 64'h00000001_0000000B, DIV_CYCLES);

      // Start held through the commit cycle is taken on the following edge
      @(negedge clk);
      start = 1'b1; op = 4'd1; d1 = 32'd3; d2 = 32'd4;
      exp_q.push_back(64'd12);
      @(negedge clk);
      chk("b2b first accept", 64'(accept), 64'd1);
      op = 4'd2; d1 = 32'd5; d2 = 32'd5;
      exp_q.push_back(64'd25);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!accept && n < 30);
      start = 1'b0;
      chk("b2b second accept gap", 64'(n), 64'(MUL_CYCLES + 1));
      pop_check("b2b first");
      wait_idle("b2b second", n);
      chk("b2b second latency", 64'(n), 64'(MUL_CYCLES));
      pop_check("b2b second");

      // HI/LO moves and NOP
      move("mthi", 4'd5, 32'hA5A50001, 64'hA5A50001_00000019);
      move("mtlo", 4'd6, 32'h00005A5A, 64'hA5A50001_00005A5A);
      move("nop", 4'd0, 32'h12345678, 64'hA5A50001_00005A5A);

      // Illegal opcode
      @(negedge clk);
      start = 1'b1; op = 4'd15; d1 = 32'h1; d2 = 32'h1;
      @(negedge clk);
      start = 1'b0;
      chk("op15 illegal", 64'(illegal), 64'd1);
      chk("op15 accept", 64'(accept), 64'd0);
      chk("op15 busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("op15 illegal once", 64'(illegal), 64'd0);
      read_hilo(v);
      chk("op15 hilo", v, 64'hA5A50001_00005A5A);

`ifdef MDU_MACC_EN
      move("macc mthi", 4'd5, 32'h0, 64'h00000000_00005A5A);
      move("macc mtlo", 4'd6, 32'hFFFFFFFF, 64'h00000000_FFFFFFFF);
      issue("maddu", 4'd8, 32'd1, 32'd1, 64'h00000001_00000000, MUL_CYCLES);
      issue("msub", 4'd9, 32'hFFFFFFFF, 32'd2, 64'h00000001_00000002, MUL_CYCLES);
      issue("madd", 4'd7, 32'hFFFFFFFF, 32'd1, 64'h00000001_00000001, MUL_CYCLES);
      issue("msubu", 4'd10, 32'd1, 32'd2, 64'h00000000_FFFFFFFF, MUL_CYCLES);
`else
      @(negedge clk);
      start = 1'b1; op = 4'd8; d1 = 32'd1; d2 = 32'd1;
      @(negedge clk);
      start = 1'b0;
      chk("op8 illegal", 64'(illegal), 64'd1);
      chk("op8 busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("op8 illegal once", 64'(illegal), 64'd0);
      read_hilo(v);
      chk("op8 hilo", v, 64'hA5A50001_00005A5A);
`endif

      // Reset during an in-flight divide discards the result
      @(negedge clk);
      start = 1'b1; op = 4'd4; d1 = 32'd100; d2 = 32'd9;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (remain != CNT_W'(4) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid reached cnt4", 64'(remain), 64'd4);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      read_hilo(v);
      chk("rstmid hilo", v, 64'd0);
      chk("rstmid busy", 64'(busy), 64'd0);
      chk("rstmid remain", 64'(remain), 64'd0);
      repeat (DIV_CYCLES + 2) @(negedge clk);
      read_hilo(v);
      chk("rstmid no commit", v, 64'd0);
      chk("rstmid busy later", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised successor to the single-cycle MDU for the pipelined CPU; sits in EX alongside the ALU.
- Accepts multiply, divide and HI/LO-move requests through a start/busy handshake.
- Holds results for a configurable latency before committing them to HI/LO.
- Exposes a remaining-cycles count so the hazard unit can stall MFHI/MFLO and new MDU ops exactly as long as needed.

Parameters:
- WIDTH, 32, operand and HI/LO register width (≥8, even)
- MUL_CYCLES, 5, cycles from accept to HI/LO commit for multiply ops (≥1)
- DIV_CYCLES, 10, cycles from accept to HI/LO commit for divide ops (≥1, ≥MUL_CYCLES)
- CNT_W, 5, width of remaining-cycles counter (2^CNT_W > DIV_CYCLES)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  request valid this cycle
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, 11–15 illegal
- d1  in  WIDTH  rs operand
- d2  in  WIDTH  rt operand
- rd_hi  in  1  read select: 1 = HI, 0 = LO
- rdata  out  WIDTH  combinational HI or LO per rd_hi (committed values only)
- busy  out  1  operation in flight
- remain  out  CNT_W  cycles until commit; 0 when idle
- accept  out  1  registered one-cycle pulse: previous-cycle start was taken
- illegal  out  1  registered one-cycle pulse: previous-cycle start rejected as illegal opcode

Behaviour:
- Reset (rst=0 at edge): HI=LO=0, cnt=0, busy=0, remain=0, accept=0, illegal=0.
  - Any in-flight operation is discarded; pending result is never committed.
- busy = (cnt != 0); remain = cnt.
- Accept condition: start && !busy && op is legal (1–10, or 1–6 without the macro).
- Start while busy: ignored, no state change, no pulse. The pipeline must hold the request.
- NOP with start: no state change; accept pulses.
- MTHI/MTLO: HI or LO ← d1 at the accepting edge. No busy. accept pulses next cycle.
- MULT/MULTU, and MADD* / MSUB* when enabled:
  - At the accepting edge, compute the 2·WIDTH result from d1/d2 and the HI/LO value at that edge.
  - Store it in a pending register; cnt ← MUL_CYCLES.
- DIV/DIVU:
  - Pending LO = quotient, HI = remainder; cnt ← DIV_CYCLES.
  - Signed ops truncate toward zero; remainder takes the sign of the dividend.
- Countdown: while cnt != 0, cnt decrements each edge.
  - On the edge where cnt goes 1→0, {HI,LO} ← pending.
  - So for an accept at edge k, busy is high after edges k..k+N−1, and new HI/LO is visible on rdata after edge k+N, the same cycle busy falls.
- Back-to-back: a new start may be accepted in the cycle busy is low. A start asserted in the commit cycle (busy already low) is accepted at the next edge.
- Divide by zero (d2=0): LO = all ones; HI = d1. Latency unchanged.
- Signed overflow (DIV with d1 = most-negative, d2 = −1): LO = most-negative, HI = 0.
- Unsigned ops treat operands as unsigned. Signed ops use two's complement.
- Multiply-accumulate wraps modulo 2^(2·WIDTH), with no saturation.
- Operands are latched at accept; later changes on d1/d2 have no effect.
- Illegal opcode with start while idle: no state change; illegal pulses.

Optional Feature:
- Macro: MDU_MACC_EN.
- Defined:
  - MADD: {HI,LO} + signed(d1·d2).
  - MADDU: {HI,LO} + unsigned(d1·d2).
  - MSUB / MSUBU: the same with subtraction.
  - All four use MUL_CYCLES latency.
- Undefined: ops 7–10 are illegal (illegal pulses, no state change). No accumulate datapath is built.

Test Plan:
- Reset/defaults: hold rst=0 for 2 cycles → rdata=0 for both rd_hi values; busy=0; remain=0.
- MULT latency: start op=1, d1=0xFFFFFFFE (−2), d2=3 → busy high for exactly 5 cycles, remain counts 5,4,3,2,1; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV, divide-by-zero, overflow (one sub-case per line of stimulus):
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles.
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Busy rejection: MULTU 6×7 accepted; start DIVU 100/9 on the next 3 cycles → ignored and no accept pulse, HI:LO = 0:42; DIVU re-issued after busy falls → LO=11, HI=1.
- Reset mid-op: start DIVU, drive rst=0 at cnt=4 → HI=LO=0, busy=0, and no later commit.
- MACC: with MDU_MACC_EN, MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Without the macro, op=8 → illegal pulses once and HI/LO are unchanged.
